// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier datapath.
// Holds the controller state encoding and the default operand/counter widths.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = $clog2(MULT_WIDTH + 2);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M, then arithmetic shift of {acc,q,q_1}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module booth_step
    import mult_pkg::*;
#(
    parameter int AW = MULT_WIDTH + 1,
    parameter int QW = MULT_WIDTH
) (
    input  logic [AW-1:0] acc,
    input  logic [QW-1:0] q,
    input  logic          q_1,
    input  logic [AW-1:0] m,
    output logic [AW-1:0] acc_nxt,
    output logic [QW-1:0] q_nxt,
    output logic          q_1_nxt
);

    logic [AW-1:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // The shift replicates the acc MSB and drops q[0] into q_1.
    assign {acc_nxt, q_nxt, q_1_nxt} = {sum[AW-1], sum, q};

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier (MULT; MULTU too when BOOTH_MULTU_EN is defined).
// Latency: start at edge E0 -> done pulse in the cycle after E0+WIDTH (E0+WIDTH+1 with BOOTH_MULTU_EN).
// Backpressure: none; start is ignored while busy, hi/lo hold until the next completed product.
module booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef BOOTH_MULTU_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // With MULTU support the multiplier gets one extension bit so unsigned
    // operands stay positive; the step count grows with it.
`ifdef BOOTH_MULTU_EN
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    localparam int AW = QW + 1;
    localparam int HB = 2 * WIDTH - QW;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    state_t             state;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      m;
    logic [QW-1:0]      q;
    logic               q_1;
    logic [CW-1:0]      cnt;

    logic [AW-1:0]      acc_nxt;
    logic [QW-1:0]      q_nxt;
    logic               q_1_nxt;
    logic [AW-1:0]      m_init;
    logic [QW-1:0]      q_init;
    logic [2*WIDTH-1:0] prod;
    logic               ext_a;

`ifdef BOOTH_MULTU_EN
    logic ext_b;
    assign ext_a  = ~is_unsigned & a[WIDTH-1];
    assign ext_b  = ~is_unsigned & b[WIDTH-1];
    assign q_init = {ext_b, b};
`else
    assign ext_a  = a[WIDTH-1];
    assign q_init = b;
`endif

    assign m_init = {{(AW - WIDTH){ext_a}}, a};
    // Low 2*WIDTH bits of the post-shift {acc,q} after the final step.
    assign prod   = {acc_nxt[HB-1:0], q_nxt};

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m     <= m_init;
                        q     <= q_init;
                        q_1   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    q_1 <= q_1_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        lo    <= prod[WIDTH-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: expected products are queued at start and popped on done.
module tb_booth_mult;

    localparam int W   = 32;
    localparam int TMO = 100;
`ifdef BOOTH_MULTU_EN
    localparam int STEPS = W + 1;
`else
    localparam int STEPS = W;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
`ifdef BOOTH_MULTU_EN
    logic         is_unsigned = 1'b0;
`endif
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic [2*W-1:0] sb[$];
    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    booth_mult dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
`ifdef BOOTH_MULTU_EN
        .is_unsigned (is_unsigned),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit uns);
        logic [2*W-1:0] sx;
        logic [2*W-1:0] sy;
        if (uns) begin
            sx = {{W{1'b0}}, x};
            sy = {{W{1'b0}}, y};
        end else begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
        end
        return sx * sy;
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit uns,
                            input bit expect_result);
        @(negedge clock);
        a     = x;
        b     = y;
        start = 1'b1;
`ifdef BOOTH_MULTU_EN
        is_unsigned = uns;
`endif
        if (expect_result) sb.push_back(model(x, y, uns));
    endtask

    // Counts negedges until done; drops start after one cycle unless hold is set,
    // and optionally pulses a stray start (a=9,b=9) at cycle poke_at.
    task automatic wait_done(input bit hold, input int poke_at, output int cycles,
                             output int busy_cyc, output bit seen);
        cycles   = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        while (!seen && cycles < TMO) begin
            @(negedge clock);
            cycles++;
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
            if (cycles == 1 && !hold) start = 1'b0;
            if (poke_at > 0 && cycles == poke_at) begin
                start = 1'b1;
                a     = 9;
                b     = 9;
            end
            if (poke_at > 0 && cycles == poke_at + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++; if (hi !== '0)   $display("FAIL reset_hi: got %h want 0", hi);     else passed++;
        total++; if (lo !== '0)   $display("FAIL reset_lo: got %h want 0", lo);     else passed++;
        total++; if (busy !== 0)  $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 0)  $display("FAIL reset_done: got %b want 0", done); else passed++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_signed_mixed();
        int cyc, bcyc;
        bit seen;
        logic [2*W-1:0] exp;
        start_op(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1);
        wait_done(1'b0, 0, cyc, bcyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (!seen) $display("FAIL mixed_done: no done within %0d cycles", TMO); else passed++;
        total++; if (cyc !== STEPS + 1) $display("FAIL mixed_latency: got %0d want %0d", cyc, STEPS + 1); else passed++;
        total++; if (bcyc !== STEPS) $display("FAIL mixed_busy: got %0d want %0d", bcyc, STEPS); else passed++;
        total++; if (hi !== exp[2*W-1:W]) $display("FAIL mixed_hi: got %h want %h", hi, exp[2*W-1:W]); else passed++;
        total++; if (lo !== exp[W-1:0]) $display("FAIL mixed_lo: got %h want %h", lo, exp[W-1:0]); else passed++;
        @(negedge clock);
        total++; if (done !== 0) $display("FAIL mixed_single_pulse: got done=%b want 0", done); else passed++;
    endtask

    task automatic test_boundary();
        int cyc, bcyc;
        bit seen;
        logic [2*W-1:0] exp;
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000;
        ta[1] = 32'h8000_0000; tb[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], 1'b0, 1'b1);
            wait_done(1'b0, 0, cyc, bcyc, seen);
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++; if (!seen) $display("FAIL boundary%0d_done: no done within %0d cycles", i, TMO); else passed++;
            total++; if (hi !== exp[2*W-1:W]) $display("FAIL boundary%0d_hi: got %h want %h", i, hi, exp[2*W-1:W]); else passed++;
            total++; if (lo !== exp[W-1:0]) $display("FAIL boundary%0d_lo: got %h want %h", i, lo, exp[W-1:0]); else passed++;
        end
    endtask

    task automatic test_ignored_start();
        int cyc, bcyc;
        bit seen;
        logic [2*W-1:0] exp;
        start_op(32'd5, 32'd6, 1'b0, 1'b1);
        wait_done(1'b0, 10, cyc, bcyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (!seen) $display("FAIL ignored_done: no done within %0d cycles", TMO); else passed++;
        total++; if (cyc !== STEPS + 1) $display("FAIL ignored_latency: got %0d want %0d", cyc, STEPS + 1); else passed++;
        total++; if (hi !== exp[2*W-1:W]) $display("FAIL ignored_hi: got %h want %h", hi, exp[2*W-1:W]); else passed++;
        total++; if (lo !== exp[W-1:0]) $display("FAIL ignored_lo: got %h want %h", lo, exp[W-1:0]); else passed++;
        repeat (3) @(negedge clock);
        total++; if (busy !== 0) $display("FAIL ignored_no_restart: got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        bit seen;
        logic [2*W-1:0] exp;
        start_op(32'd2, 32'd3, 1'b0, 1'b1);
        sb.push_back(model(32'd2, 32'd3, 1'b0));
        wait_done(1'b1, 0, cyc, bcyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (!seen) $display("FAIL b2b_first_done: no done within %0d cycles", TMO); else passed++;
        total++; if (lo !== exp[W-1:0]) $display("FAIL b2b_first_lo: got %h want %h", lo, exp[W-1:0]); else passed++;
        wait_done(1'b0, 0, cyc, bcyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (!seen) $display("FAIL b2b_second_done: no done within %0d cycles", TMO); else passed++;
        total++; if (cyc !== STEPS + 1) $display("FAIL b2b_gap: got %0d want %0d", cyc, STEPS + 1); else passed++;
        total++; if (hi !== exp[2*W-1:W]) $display("FAIL b2b_second_hi: got %h want %h", hi, exp[2*W-1:W]); else passed++;
        total++; if (lo !== exp[W-1:0]) $display("FAIL b2b_second_lo: got %h want %h", lo, exp[W-1:0]); else passed++;
    endtask

    task automatic test_reset_abort();
        int cyc, bcyc;
        bit seen;
        int n_done, n_busy;
        logic [2*W-1:0] exp;
        start_op(32'd100, 32'd100, 1'b0, 1'b0);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (hi !== '0)  $display("FAIL abort_hi: got %h want 0", hi);     else passed++;
        total++; if (lo !== '0)  $display("FAIL abort_lo: got %h want 0", lo);     else passed++;
        total++; if (busy !== 0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        @(negedge clock);
        reset  = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        total++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", n_done); else passed++;
        total++; if (n_busy !== 0) $display("FAIL abort_idle: got %0d busy cycles want 0", n_busy); else passed++;
        start_op(32'd3, 32'd4, 1'b0, 1'b1);
        wait_done(1'b0, 0, cyc, bcyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++; if (!seen) $display("FAIL abort_next_done: no done within %0d cycles", TMO); else passed++;
        total++; if (hi !== exp[2*W-1:W]) $display("FAIL abort_next_hi: got %h want %h", hi, exp[2*W-1:W]); else passed++;
        total++; if (lo !== exp[W-1:0]) $display("FAIL abort_next_lo: got %h want %h", lo, exp[W-1:0]); else passed++;
    endtask

`ifdef BOOTH_MULTU_EN
    task automatic test_multu();
        int cyc, bcyc;
        bit seen;
        logic [2*W-1:0] exp;
        for (int u = 1; u >= 0; u--) begin
            start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, (u == 1), 1'b1);
            wait_done(1'b0, 0, cyc, bcyc, seen);
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++; if (!seen) $display("FAIL multu%0d_done: no done within %0d cycles", u, TMO); else passed++;
            total++; if (cyc !== STEPS + 1) $display("FAIL multu%0d_latency: got %0d want %0d", u, cyc, STEPS + 1); else passed++;
            total++; if (hi !== exp[2*W-1:W]) $display("FAIL multu%0d_hi: got %h want %h", u, hi, exp[2*W-1:W]); else passed++;
            total++; if (lo !== exp[W-1:0]) $display("FAIL multu%0d_lo: got %h want %h", u, lo, exp[W-1:0]); else passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_signed_mixed();
        test_boundary();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
`ifdef BOOTH_MULTU_EN
        test_multu();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
